// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// - WIDTH_DEFAULT / SEG_WIDTH_DEFAULT: default datapath and segment widths.
// - calc_stages(): pipeline depth (also the latency in cycles).
// - OVF_RULE: selects how the signed overflow flag is derived.
package adder_pkg;

  localparam int unsigned WIDTH_DEFAULT     = 16;
  localparam int unsigned SEG_WIDTH_DEFAULT = 4;

  // Both rules give identical results; the carry-xor form is cheaper when the
  // MSB carry-in is already available from the ripple chain.
  typedef enum logic {
    OvfSignCompare,
    OvfCarryXor
  } ovf_rule_e;

  localparam ovf_rule_e OVF_RULE = OvfSignCompare;

  function automatic int unsigned calc_stages(input int unsigned width,
                                              input int unsigned seg_width);
    return (seg_width == 0) ? 0 : width / seg_width;
  endfunction

endpackage

// File: rtl/adder_seg_v.sv
// Combinational SEG_WIDTH-bit ripple-carry segment built from full_adder_v.
// Ports:
//   i_a, i_b        segment operands
//   i_carry         carry into the segment LSB
//   o_s             segment sum
//   o_carry         carry out of the segment MSB
//   o_msb_carry_in  carry into the segment MSB (for carry-xor overflow)
module adder_seg_v
  import adder_pkg::*;
#(
  parameter int unsigned SEG_WIDTH = SEG_WIDTH_DEFAULT
) (
  input  logic [SEG_WIDTH-1:0] i_a,
  input  logic [SEG_WIDTH-1:0] i_b,
  input  logic                 i_carry,
  output logic [SEG_WIDTH-1:0] o_s,
  output logic                 o_carry,
  output logic                 o_msb_carry_in
);

  logic [SEG_WIDTH:0] chain;

  assign chain[0] = i_carry;

  for (genvar i = 0; i < SEG_WIDTH; i++) begin : g_bit
    full_adder_v u_fa (
      .i_a    (i_a[i]),
      .i_b    (i_b[i]),
      .i_carry(chain[i]),
      .o_s    (o_s[i]),
      .o_carry(chain[i+1])
    );
  end

  assign o_carry        = chain[SEG_WIDTH];
  assign o_msb_carry_in = chain[SEG_WIDTH-1];

endmodule

// File: rtl/full_adder_v.sv
// Single-bit full adder.
// Ports:
//   i_a, i_b  operand bits
//   i_carry   carry-in
//   o_s       sum bit
//   o_carry   carry-out
module full_adder_v (
  input  logic i_a,
  input  logic i_b,
  input  logic i_carry,
  output logic o_s,
  output logic o_carry
);

  assign o_s     = i_a ^ i_b ^ i_carry;
  assign o_carry = (i_a & i_b) | (i_carry & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder_v.sv
// Pipelined WIDTH-bit add/subtract unit. One SEG_WIDTH-bit segment is resolved
// per stage with the carry registered between stages; latency is
// STAGES = WIDTH/SEG_WIDTH cycles. A single global stall (adv) freezes every
// stage, so tokens never reorder, drop or duplicate.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     input handshake (o_ready = adv, combinational)
//   i_a, i_b, i_carry     operands and carry-in (i_carry ignored when i_sub=1)
//   i_sub                 0: a+b+carry, 1: a-b as a+~b+1
//   o_valid / i_ready     output handshake
//   o_sum, o_carry        result and MSB carry-out (1 = no borrow on subtract)
//   o_overflow            signed overflow
module pipelined_adder_v
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH     = WIDTH_DEFAULT,
  parameter int unsigned SEG_WIDTH = SEG_WIDTH_DEFAULT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int unsigned STAGES = calc_stages(WIDTH, SEG_WIDTH);

  if ((SEG_WIDTH < 1) || ((WIDTH % ((SEG_WIDTH < 1) ? 1 : SEG_WIDTH)) != 0)) begin : g_bad_params
    $error("pipelined_adder_v: WIDTH must be a non-zero multiple of SEG_WIDTH");
  end

  // Per-stage state. a_q/b_q are the skew registers carrying the operands
  // (b already in effective form) forward; sum_q accumulates the completed
  // low segments as the token moves up the pipe.
  logic             valid_q [STAGES];
  logic             carry_q [STAGES];
  logic             ovf_q   [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             carry_eff;

  assign o_valid = valid_q[STAGES-1];
  assign adv     = i_ready | ~o_valid;
  assign o_ready = adv;

  assign b_eff     = i_sub ? ~i_b : i_b;
  assign carry_eff = i_sub | i_carry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 v_in;
    logic                 c_in;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic [WIDTH-1:0]     s_in;
    logic [WIDTH-1:0]     s_next;
    logic [SEG_WIDTH-1:0] seg_s;
    logic                 seg_cout;
    logic                 seg_msb_cin;
    logic                 ovf_sign;
    logic                 ovf_next;

    if (k == 0) begin : g_first
      assign v_in = i_valid;
      assign c_in = carry_eff;
      assign a_in = i_a;
      assign b_in = b_eff;
      assign s_in = '0;
    end else begin : g_next
      assign v_in = valid_q[k-1];
      assign c_in = carry_q[k-1];
      assign a_in = a_q[k-1];
      assign b_in = b_q[k-1];
      assign s_in = sum_q[k-1];
    end

    adder_seg_v #(
      .SEG_WIDTH(SEG_WIDTH)
    ) u_seg (
      .i_a           (a_in[k*SEG_WIDTH +: SEG_WIDTH]),
      .i_b           (b_in[k*SEG_WIDTH +: SEG_WIDTH]),
      .i_carry       (c_in),
      .o_s           (seg_s),
      .o_carry       (seg_cout),
      .o_msb_carry_in(seg_msb_cin)
    );

    always_comb begin
      s_next                               = s_in;
      s_next[k*SEG_WIDTH +: SEG_WIDTH]     = seg_s;
    end

    // Overflow is only meaningful in the final stage, where the MSB segment
    // is resolved; earlier stages compute it too but it is never observed.
    assign ovf_sign = (a_in[WIDTH-1] == b_in[WIDTH-1]) & (s_next[WIDTH-1] != a_in[WIDTH-1]);
    assign ovf_next = (OVF_RULE == OvfCarryXor) ? (seg_cout ^ seg_msb_cin) : ovf_sign;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        ovf_q[k]   <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
      end else if (adv) begin
        valid_q[k] <= v_in;
        carry_q[k] <= seg_cout;
        ovf_q[k]   <= ovf_next;
        a_q[k]     <= a_in;
        b_q[k]     <= b_in;
        sum_q[k]   <= s_next;
      end
    end
  end

  assign o_sum      = sum_q[STAGES-1];
  assign o_carry    = carry_q[STAGES-1];
  assign o_overflow = ovf_q[STAGES-1];

endmodule
